mod_updown_counter: RTL
=======================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, count register width in bits.
REQ-002 SHALL have parameter MODULUS, default 16, number of count states (range 0..MODULUS-1); legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable; count holds when low.
REQ-006 SHALL have port up_down  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port sat  input  1  boundary mode: 0 = wrap, 1 = saturate.
REQ-008 SHALL have port load  input  1  synchronous load strobe (present only with macro, see Configuration).
REQ-009 SHALL have port load_value  input  WIDTH  value to load (present only with macro).
REQ-010 SHALL have port count  output  WIDTH  current count, registered.
REQ-011 SHALL have port tc  output  1  terminal-count flag, combinational from count and up_down.
REQ-012 SHALL have port wrap  output  1  one-cycle registered pulse on a wrap event.

Function
REQ-013 SHALL apply per-edge priority: reset > load > en > hold.
REQ-014 SHALL, when en=1 and up_down=1, increment count by 1 if count < MODULUS-1.
REQ-015 SHALL, when en=1 and up_down=1 and count = MODULUS-1: with sat=0 set count to 0 and assert wrap next cycle; with sat=1 hold MODULUS-1, wrap stays 0.
REQ-016 SHALL, when en=1 and up_down=0, decrement count by 1 if count > 0.
REQ-017 SHALL, when en=1 and up_down=0 and count = 0: with sat=0 set count to MODULUS-1 and assert wrap; with sat=1 hold 0, wrap stays 0.
REQ-018 SHALL drive tc=1 when (up_down=1 and count=MODULUS-1) or (up_down=0 and count=0), independent of en and sat.
REQ-019 SHALL assert wrap for exactly the one cycle following the wrapping edge; wrap=0 on every other cycle, including hold, load and saturate cycles.
REQ-020 SHALL sample up_down and sat on each edge; a direction or mode change takes effect on the same edge with no pipeline delay.
REQ-021 SHALL, on load, set count to load_value if load_value <= MODULUS-1, else to MODULUS-1; a load edge SHALL NOT produce wrap.
REQ-022 SHALL keep count within 0..MODULUS-1 at all times; no intermediate value outside range is ever visible.
REQ-023 SHALL, when MODULUS = 2**WIDTH, behave as a natural binary wrap counter (WIDTH=4, MODULUS=16 reproduces the legacy 4-bit up/down counter).

Reset
REQ-024 SHALL, on reset=1 at a rising edge, set count=0 and wrap=0 regardless of en, load, up_down or sat.
REQ-025 SHALL, when reset is asserted mid-count, discard the in-progress update; the first edge after reset deasserts counts from 0.
REQ-026 SHALL have no asynchronous reset path and no initial-value dependency for correct operation.

Configuration
REQ-027 SHALL compile the load feature (load, load_value ports, REQ-021) only when macro MOD_UPDOWN_COUNTER_LOAD_EN is defined.
REQ-028 SHALL, without MOD_UPDOWN_COUNTER_LOAD_EN, omit load and load_value ports entirely; priority reduces to reset > en > hold and all other behaviour is unchanged.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-029 SHALL cover: reset=1 two edges, then en=1, up_down=1, sat=0 for 12 edges -> count 1..9, 0, 1, 2; wrap high only the cycle count=0 appears; tc=1 while count=9.
REQ-030 SHALL cover: count=0, up_down=0, sat=0, en=1 -> next count=9, wrap pulse 1 cycle; then count=8.
REQ-031 SHALL cover: sat=1, count up to 9, 3 more enabled edges -> count holds 9, wrap never asserts; switch up_down=0 -> count 8.
REQ-032 SHALL cover (macro defined): load=1, load_value=6 with en=1 -> count=6; load_value=13 -> count=9; no wrap on either.
REQ-033 SHALL cover: reset=1 asserted when count=7 with en=1 -> count=0, wrap=0 next edge; en=0 for 3 edges -> count holds.
REQ-034 SHALL cover: WIDTH=4, MODULUS=16, up 16 edges from 0 -> count 15 then 0 with wrap pulse (legacy equivalence).

Source files
------------

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// Modulo-N up/down counter with selectable wrap or saturate behaviour at the
// range boundaries, a combinational terminal-count flag and a one-cycle wrap
// pulse. With MODULUS = 2**WIDTH it behaves as a plain binary up/down counter.
//
// Optional feature: define MOD_UPDOWN_COUNTER_LOAD_EN to add a synchronous
// load (load / load_value). Without the macro those ports do not exist.
//
// Parameters
//   WIDTH      count register width in bits
//   MODULUS    number of count states, count range 0..MODULUS-1
//              (2 <= MODULUS <= 2**WIDTH)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset (count=0, wrap=0)
//   en         count enable; count holds when low
//   up_down    direction: 1 = up, 0 = down
//   sat        boundary mode: 0 = wrap, 1 = saturate
//   load       synchronous load strobe        (MOD_UPDOWN_COUNTER_LOAD_EN only)
//   load_value value to load, clamped to range (MOD_UPDOWN_COUNTER_LOAD_EN only)
//   count      current count, registered
//   tc         terminal count: at the boundary in the current direction
//   wrap       registered pulse, high for the cycle after a wrapping edge
//
// Edge priority: reset > load > en > hold.
// -----------------------------------------------------------------------------
module mod_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             sat,
`ifdef MOD_UPDOWN_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Highest legal count value.
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_count;
    logic             next_wrap;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (count == MAX_COUNT);
    assign at_bottom = (count == '0);

    // Terminal count looks only at count and direction, never at en or sat.
    assign tc = up_down ? at_top : at_bottom;

    // Next-state selection. Reset is handled in the register block so that it
    // overrides everything here, including load.
    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
`ifdef MOD_UPDOWN_COUNTER_LOAD_EN
        if (load) begin
            // Out-of-range load values clamp to the top of the range; a load
            // never counts as a wrap.
            next_count = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
        end else
`endif
        if (en) begin
            if (up_down) begin
                if (!at_top) begin
                    next_count = count + WIDTH'(1);
                end else if (!sat) begin
                    next_count = '0;
                    next_wrap  = 1'b1;
                end
            end else begin
                if (!at_bottom) begin
                    next_count = count - WIDTH'(1);
                end else if (!sat) begin
                    next_count = MAX_COUNT;
                    next_wrap  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
        end
    end

endmodule
